// File: rtl/mem_arbiter.sv
// Shares one single-port byte-enabled BRAM between the CPU fetch (I) and load/store (D) ports.
// One access per two cycles: grant and address in IDLE, formatted response in RESP.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [BUS_WIDTH-1:0]  i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [BUS_WIDTH-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [BUS_WIDTH-1:0]  d_rdata,
    output logic                  d_err,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BUS_WIDTH-1:0]  ram_data,
    input  logic [BUS_WIDTH-1:0]  ram_out
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state;
    logic                 last_d;
    logic                 we_q;
    logic                 uns_q;
    logic                 err_q;
    logic [1:0]           size_q;
    logic [1:0]           off_q;

    logic                 idle;
    logic                 pick_d;
    logic                 pick_i;
    logic                 d_bad;
    logic                 i_bad;
    logic [3:0]           lanes;
    logic [BUS_WIDTH-1:0] rep;
    logic [BUS_WIDTH-1:0] word;
    logic [7:0]           lb;
    logic [15:0]          lh;
    logic                 unused_addr;

    // Alias: address bits above the BRAM word range are deliberately dropped.
    assign unused_addr = ^{i_addr[31:ADDR_WIDTH+2], d_addr[31:ADDR_WIDTH+2]};
    assign idle        = (state == IDLE) && !reset;

    always_comb begin
        // Round-robin: on a tie, the port that did not win last time goes next.
        pick_d = d_req && (!i_req || !last_d);
        pick_i = i_req && !pick_d;
        d_bad  = (d_size == 2'b11) ||
                 (d_size == 2'b01 && d_addr[0]) ||
                 (d_size == 2'b10 && d_addr[1:0] != 2'b00);
        i_bad  = (i_addr[1:0] != 2'b00);
        case (d_size)
            2'b00: begin
                lanes = 4'b0001 << d_addr[1:0];
                rep   = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                lanes = d_addr[1] ? 4'b1100 : 4'b0011;
                rep   = {2{d_wdata[15:0]}};
            end
            default: begin
                lanes = 4'b1111;
                rep   = d_wdata;
            end
        endcase
        i_gnt    = idle && pick_i;
        d_gnt    = idle && pick_d;
        ram_we   = '0;
        ram_addr = '0;
        ram_data = '0;
        if (d_gnt) begin
            ram_addr = d_addr[ADDR_WIDTH+1:2];
            if (d_we) ram_data = rep;
            if (d_we && !d_bad) ram_we = lanes;
        end else if (i_gnt) begin
            ram_addr = i_addr[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            size_q <= '0;
            off_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_gnt || d_gnt) begin
                        state  <= RESP;
                        last_d <= d_gnt;
                        we_q   <= d_gnt && d_we;
                        uns_q  <= d_gnt && d_unsigned;
                        size_q <= d_gnt ? d_size : 2'b10;
                        off_q  <= d_gnt ? d_addr[1:0] : i_addr[1:0];
                        err_q  <= d_gnt ? d_bad : i_bad;
                    end
                end
                RESP: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        lb = ram_out[{off_q, 3'b000} +: 8];
        lh = off_q[1] ? ram_out[31:16] : ram_out[15:0];
        case (size_q)
            2'b00:   word = {{24{!uns_q && lb[7]}}, lb};
            2'b01:   word = {{16{!uns_q && lh[15]}}, lh};
            default: word = ram_out;
        endcase
        i_rvalid = (state == RESP) && !last_d;
        d_rvalid = (state == RESP) && last_d;
        i_err    = i_rvalid && err_q;
        d_err    = d_rvalid && err_q;
        i_rdata  = (i_rvalid && !err_q) ? ram_out : '0;
        d_rdata  = (d_rvalid && !err_q && !we_q) ? word : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: BRAM environment model, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_size = '0;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_data;
    logic [31:0] ram_out = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_arbiter #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // BRAM environment: byte-enabled write, registered read.
    logic [31:0] bram [0:8191];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (ram_we[k]) bram[ram_addr][8*k +: 8] <= ram_data[8*k +: 8];
        ram_out <= bram[ram_addr];
    end

    // Golden byte-addressed memory (15-bit byte address space).
    logic [7:0] gmem [0:32767];

    function automatic logic [31:0] gword(input int unsigned a);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = w | (32'(gmem[(a + k) & 32'h7FFF]) << (8 * k));
        return w;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        bram[a[14:2]] = w;
        for (int k = 0; k < 4; k++) gmem[(a & 32'h7FFC) + k] = 8'((w >> (8 * k)) & 32'hFF);
    endtask

    // Reference model: one access in flight, response due the following cycle.
    bit          m_busy = 0;
    bit          m_last_d = 0;
    bit          m_pd = 0;
    bit          m_err = 0;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin
        int unsigned a, nb, off;
        bit          any, win_d;
        logic [31:0] exp_we, exp_data, pat;
        longint      v;
        if (reset) begin
            check("rst_ctl", {22'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, ram_we}, 0);
            check("rst_addr", {19'b0, ram_addr}, 0);
            check("rst_wdata", ram_data, 0);
            check("rst_rdata", i_rdata | d_rdata, 0);
            m_busy = 0;
            m_last_d = 0;
        end else if (m_busy) begin
            check("resp_gnt", {30'b0, i_gnt, d_gnt}, 0);
            check("resp_we", {28'b0, ram_we}, 0);
            check("resp_valid", {30'b0, i_rvalid, d_rvalid}, m_pd ? 32'd1 : 32'd2);
            if (m_pd) begin
                check("d_err", {31'b0, d_err}, {31'b0, m_err});
                check("d_rdata", d_rdata, m_rdata);
            end else begin
                check("i_err", {31'b0, i_err}, {31'b0, m_err});
                check("i_rdata", i_rdata, m_rdata);
            end
            m_busy = 0;
        end else begin
            any = i_req || d_req;
            win_d = (i_req && d_req) ? !m_last_d : d_req;
            check("idle_valid", {30'b0, i_rvalid, d_rvalid}, 0);
            check("idle_gnt", {30'b0, i_gnt, d_gnt}, !any ? 32'd0 : (win_d ? 32'd1 : 32'd2));
            if (!any) begin
                check("idle_we", {28'b0, ram_we}, 0);
            end else if (win_d) begin
                a = d_addr & 32'h7FFF;
                off = a % 4;
                nb = (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : 4;
                m_err = (d_size == 2'd3) || (a % nb != 0);
                exp_we = 0;
                m_rdata = 0;
                if (d_we && !m_err) begin
                    exp_we = ((32'd1 << nb) - 1) << off;
                    pat = (nb == 4) ? d_wdata : d_wdata & ((32'd1 << (8 * nb)) - 1);
                    exp_data = (nb == 1) ? pat * 32'h01010101 : (nb == 2) ? pat * 32'h00010001 : pat;
                    check("st_data", ram_data, exp_data);
                    for (int k = 0; k < int'(nb); k++) gmem[a + k] = 8'((d_wdata >> (8 * k)) & 32'hFF);
                end else if (!d_we && !m_err) begin
                    v = 0;
                    for (int k = 0; k < int'(nb); k++) v += longint'(gmem[a + k]) << (8 * k);
                    if (!d_unsigned && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                        v -= longint'(1) << (8 * nb);
                    m_rdata = 32'(v);
                end
                check("d_we_lanes", {28'b0, ram_we}, exp_we);
                check("d_ram_addr", {19'b0, ram_addr}, a / 4);
                m_pd = 1;
                m_last_d = 1;
                m_busy = 1;
            end else begin
                a = i_addr & 32'h7FFF;
                m_err = (a % 4) != 0;
                m_rdata = m_err ? 32'd0 : gword(a);
                check("i_we", {28'b0, ram_we}, 0);
                check("i_ram_addr", {19'b0, ram_addr}, a / 4);
                m_pd = 0;
                m_last_d = 0;
                m_busy = 1;
            end
        end
    end

    // Directed access helpers: entered and left at posedge+1.
    task automatic d_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata,
                            output logic [3:0] gwe, output logic [31:0] rd, output logic err,
                            output logic [31:0] gdat);
        int unsigned n = 0;
        d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata; d_req = 1'b1;
        @(negedge clk);
        while (!d_gnt && n < 20) begin n++; @(negedge clk); end
        check("d_gnt_wait", {31'b0, d_gnt}, 1);
        gwe = ram_we;
        gdat = ram_data;
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        check("d_rvalid_lat", {31'b0, d_rvalid}, 1);
        rd = d_rdata;
        err = d_err;
        @(posedge clk); #1;
    endtask

    task automatic i_access(input logic [31:0] addr, output logic [31:0] rd, output logic err);
        int unsigned n = 0;
        i_addr = addr; i_req = 1'b1;
        @(negedge clk);
        while (!i_gnt && n < 20) begin n++; @(negedge clk); end
        check("i_gnt_wait", {31'b0, i_gnt}, 1);
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        check("i_rvalid_lat", {31'b0, i_rvalid}, 1);
        rd = i_rdata;
        err = i_err;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] size);
        logic [31:0] a;
        logic [1:0]  off;
        a = 32'h400 + ($urandom_range(0, 63) << 2);
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF8000);
        off = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) off = (size == 2'd1) ? (off & 2'b10) : (size == 2'd0) ? off : 2'b00;
        return a | {30'b0, off};
    endfunction

    task automatic rand_i(input int cycles);
        logic seen;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); seen = i_gnt;
            @(posedge clk); #1;
            if (i_req && seen) i_req = 1'b0;
            else if (i_req && $urandom_range(0, 15) == 0) i_req = 1'b0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_addr = rand_addr(2'd2);
                i_req = 1'b1;
            end
        end
        i_req = 1'b0;
    endtask

    task automatic rand_d(input int cycles);
        logic seen;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); seen = d_gnt;
            @(posedge clk); #1;
            if (d_req && seen) d_req = 1'b0;
            else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                d_we = 1'($urandom_range(0, 1));
                d_unsigned = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                d_addr = rand_addr(d_size);
                d_req = 1'b1;
            end
        end
        d_req = 1'b0;
    endtask

    logic [3:0]  gwe;
    logic [31:0] gdat, r;
    logic        e;
    logic [3:0]  cpat [0:3] = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};

    initial begin
        for (int k = 0; k < 8192; k++) bram[k] = '0;
        for (int k = 0; k < 32768; k++) gmem[k] = '0;
        // Both ports requesting straight out of reset: D, I, D, I every other cycle.
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'd2;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("contend", {28'b0, d_gnt, i_gnt, d_rvalid, i_rvalid}, {28'b0, cpat[k % 4]});
        end
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;

        preload(32'h100, 32'hDEADBEEF);
        i_access(32'h100, r, e);
        check("fetch_data", r, 32'hDEADBEEF);
        check("fetch_err", {31'b0, e}, 0);

        preload(32'h200, 32'h11223344);
        d_access(1'b1, 32'h203, 2'd0, 1'b0, 32'h000000A5, gwe, r, e, gdat);
        check("sb_we", {28'b0, gwe}, 32'h8);
        check("sb_data", gdat, 32'hA5A5A5A5);
        check("sb_ack", r, 0);
        d_access(1'b0, 32'h203, 2'd0, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lb", r, 32'hFFFFFFA5);
        d_access(1'b0, 32'h203, 2'd0, 1'b1, 32'h0, gwe, r, e, gdat);
        check("lbu", r, 32'h000000A5);
        d_access(1'b0, 32'h200, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lw_after_sb", r, 32'hA5223344);

        preload(32'h300, 32'h80017FFF);
        d_access(1'b0, 32'h302, 2'd1, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lh_hi", r, 32'hFFFF8001);
        d_access(1'b0, 32'h302, 2'd1, 1'b1, 32'h0, gwe, r, e, gdat);
        check("lhu_hi", r, 32'h00008001);
        d_access(1'b0, 32'h300, 2'd1, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lh_lo", r, 32'h00007FFF);
        d_access(1'b1, 32'h302, 2'd1, 1'b0, 32'h00001234, gwe, r, e, gdat);
        check("sh_we", {28'b0, gwe}, 32'hC);
        d_access(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lw_after_sh", r, 32'h12347FFF);

        d_access(1'b0, 32'h102, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("lw_mis_we", {28'b0, gwe}, 0);
        check("lw_mis_err", {31'b0, e}, 1);
        check("lw_mis_data", r, 0);
        d_access(1'b1, 32'h101, 2'd1, 1'b0, 32'h0000FFFF, gwe, r, e, gdat);
        check("sh_mis_we", {28'b0, gwe}, 0);
        check("sh_mis_err", {31'b0, e}, 1);
        d_access(1'b1, 32'h100, 2'd3, 1'b0, 32'h0, gwe, r, e, gdat);
        check("size11_we", {28'b0, gwe}, 0);
        check("size11_err", {31'b0, e}, 1);
        d_access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("mem_unchanged", r, 32'hDEADBEEF);
        i_access(32'h006, r, e);
        check("fetch_mis_err", {31'b0, e}, 1);
        check("fetch_mis_data", r, 0);
        d_access(1'b0, 32'hFFFF8300, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("alias_lw", r, 32'h12347FFF);

        // Reset landing in the response cycle discards the pending response at once.
        d_we = 1'b0; d_addr = 32'h100; d_size = 2'd2; d_req = 1'b1;
        @(negedge clk);
        check("rst_pre_gnt", {31'b0, d_gnt}, 1);
        @(posedge clk); #1 d_req = 1'b0;
        check("rst_pre_valid", {31'b0, d_rvalid}, 1);
        #1 reset = 1'b1;
        #1 check("rst_async_valid", {31'b0, d_rvalid}, 0);
        @(posedge clk); #1 reset = 1'b0;
        d_access(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, gwe, r, e, gdat);
        check("post_rst_lw", r, 32'h12347FFF);
        check("post_rst_err", {31'b0, e}, 0);

        fork
            rand_i(2000);
            rand_d(2000);
        join
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
